// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and frame command codes.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_RD_SHIFT  = 3'd6,
    ST_DONE      = 3'd7
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register; q_o[W-1] is the serial output.
module spi_shift_reg #(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  input  logic         shift_i,
  input  logic         si_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else if (load_i) begin
      q_q <= d_i;
    end else if (shift_i) begin
      q_q <= {q_q[W-2:0], si_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave, one bit per clk while SS_n is low: 2-bit command + DATA_W payload,
// write frames complete immediately, read-data frames return DATA_W bits on MISO.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

  localparam int unsigned       FRAME_W  = DATA_W + 2;
  localparam int unsigned       CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_W - 1);
  localparam logic [DATA_W:0]   TX_IDLE  = {MISO_IDLE, {DATA_W{1'b0}}};
  localparam logic [DATA_W-1:0] TX_MARK  = {1'b1, {(DATA_W-1){1'b0}}};

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W+1:0] rx_data_q;
  logic              rx_valid_q;
  logic              frame_err_q;

  logic [DATA_W:0]   rx_q;
  logic [DATA_W:0]   tx_q;
  logic [DATA_W:0]   tx_d;

  logic capturing, last_bit, tx_done;
  logic frame_done, abort, rx_shift;
  logic tx_load, tx_shift, tx_end, tx_clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!SS_n) state_d = ST_CHK_CMD;
      ST_CHK_CMD: begin
        if (SS_n)                          state_d = ST_IDLE;
        else if (MOSI == CMD_WR_ADDR[1])   state_d = ST_WRITE;
        else if (rd_pend_q)                state_d = ST_READ_DATA;
        else                               state_d = ST_READ_ADD;
      end
      ST_WRITE,
      ST_READ_ADD: begin
        if (SS_n)          state_d = ST_IDLE;
        else if (last_bit) state_d = ST_DONE;
      end
      ST_READ_DATA: begin
        if (SS_n)          state_d = ST_IDLE;
        else if (last_bit) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (SS_n)          state_d = ST_IDLE;
        else if (tx_valid) state_d = ST_RD_SHIFT;
      end
      ST_RD_SHIFT: begin
        if (SS_n)          state_d = ST_IDLE;
        else if (tx_done)  state_d = ST_DONE;
      end
      ST_DONE:      if (SS_n) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // tx shifter carries a trailing marker bit: when it lands just below the MSB,
  // the last payload bit is on MISO and the next edge restores the idle level.
  always_comb begin
    capturing  = (state_q == ST_WRITE) || (state_q == ST_READ_ADD) ||
                 (state_q == ST_READ_DATA);
    last_bit   = (bit_cnt_q == LAST_CNT);
    tx_done    = (tx_q[DATA_W-1:0] == TX_MARK);
    abort      = SS_n && (state_q != ST_IDLE) && (state_q != ST_DONE);
    frame_done = capturing && !SS_n && last_bit;
    rx_shift   = !SS_n && ((state_q == ST_CHK_CMD) || (capturing && !last_bit));
    bit_cnt_d  = rx_shift ? bit_cnt_q + 1'b1 : '0;
    tx_load    = (state_q == ST_RD_WAIT) && !SS_n && tx_valid;
    tx_end     = (state_q == ST_RD_SHIFT) && !SS_n && tx_done;
    tx_shift   = (state_q == ST_RD_SHIFT) && !SS_n && !tx_done;
    tx_clear   = abort || tx_end;
    tx_d       = tx_load ? {tx_data, 1'b1} : TX_IDLE;
    rd_pend_d  = rd_pend_q;
    if (frame_done && (state_q == ST_READ_ADD)) rd_pend_d = 1'b1;
    if (tx_end)                                 rd_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rx_valid_q  <= frame_done;
      frame_err_q <= abort;
      if (frame_done) rx_data_q <= {rx_q, MOSI};
    end
  end

  spi_shift_reg #(
    .W       (DATA_W + 1),
    .RST_VAL ('0)
  ) u_rx_sr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (1'b0),
    .d_i     ('0),
    .shift_i (rx_shift),
    .si_i    (MOSI),
    .q_o     (rx_q)
  );

  spi_shift_reg #(
    .W       (DATA_W + 1),
    .RST_VAL (TX_IDLE)
  ) u_tx_sr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tx_load || tx_clear),
    .d_i     (tx_d),
    .shift_i (tx_shift),
    .si_i    (1'b0),
    .q_o     (tx_q)
  );

  assign MISO      = tx_q[DATA_W];
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame; legal range 4..32.
REQ-002 Parameter MISO_IDLE, default 1'b0, MISO level whenever no read data is being shifted.
REQ-003 Frame word width is FRAME_W = DATA_W+2: 2 command bits followed by DATA_W payload bits.
REQ-004 clk  input  1  single system clock; MOSI/SS_n sampled and MISO driven on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 SS_n  input  1  slave select, active-low; frames a transaction.
REQ-007 MOSI  input  1  serial data in, MSB first, one bit per clk while SS_n=0.
REQ-008 MISO  output  1  serial data out, MSB first, registered.
REQ-009 rx_data  output  FRAME_W  received frame {cmd[1:0], payload}.
REQ-010 rx_valid  output  1  one-cycle pulse qualifying rx_data.
REQ-011 tx_data  input  DATA_W  read data from memory side.
REQ-012 tx_valid  input  1  qualifies tx_data; honoured only in RD_WAIT.
REQ-013 frame_err  output  1  one-cycle pulse: SS_n rose before FRAME_W bits received or before read data fully shifted.

Function
REQ-014 States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT, DONE.
REQ-015 IDLE: SS_n=0 -> CHK_CMD next cycle; no bit captured in IDLE.
REQ-016 CHK_CMD: captures MOSI as frame bit FRAME_W-1; MOSI=0 -> WRITE; MOSI=1 and rd_pend=0 -> READ_ADD; MOSI=1 and rd_pend=1 -> READ_DATA.
REQ-017 WRITE/READ_ADD/READ_DATA capture remaining FRAME_W-1 bits, one per clk, MSB first, into a shift register; bit counter width $clog2(FRAME_W+1).
REQ-018 On the edge sampling the last frame bit: rx_data <= full frame, rx_valid=1 in the following cycle for exactly one cycle.
REQ-019 After last bit: WRITE/READ_ADD -> DONE; READ_DATA -> RD_WAIT.
REQ-020 READ_ADD completion sets rd_pend; RD_SHIFT completion clears rd_pend; rd_pend otherwise unchanged, including across frame errors.
REQ-021 RD_WAIT: on tx_valid=1, tx_data latched into output shift register, -> RD_SHIFT; waits indefinitely while SS_n=0.
REQ-022 RD_SHIFT: MISO driven with bit DATA_W-1 down to 0, one per clk, first bit in the cycle after tx_valid is seen; after DATA_W bits -> DONE, MISO returns to MISO_IDLE.
REQ-023 DONE: extra MOSI bits ignored; rx_valid not reasserted; SS_n=1 -> IDLE.
REQ-024 SS_n=1 in any state other than IDLE/DONE: -> IDLE next cycle, partial frame discarded, rx_data unchanged, no rx_valid, frame_err pulses one cycle (except from RD_WAIT before tx_valid, which also pulses).
REQ-025 rx_valid and frame_err never high in the same cycle; rx_data holds its value until the next completed frame.
REQ-026 tx_valid outside RD_WAIT ignored.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE, MISO=MISO_IDLE, rx_data=0, rx_valid=0, frame_err=0, rd_pend=0, counters=0.
REQ-028 Reset mid-frame aborts with no rx_valid and no frame_err pulse.

Structure
REQ-029 Shared package spi_pkg holds state enum encoding (3 bits) and command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
REQ-030 One sub-module spi_shift_reg (parametrised width, load/shift/serial-in/serial-out) used for both receive and transmit paths.
REQ-031 Separate registered next-state logic and state register.

Verification
REQ-032 DATA_W=8: SS_n low, shift 00_1010_0101 -> rx_valid one cycle, rx_data=10'h0A5, then DONE until SS_n high.
REQ-033 Shift 10_0011_1100 -> rx_data=10'h23C, rd_pend=1; next frame 11_xxxx_xxxx -> READ_DATA, rx_data=10'h3xx, RD_WAIT; tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on next 8 cycles, rd_pend=0.
REQ-034 SS_n high after 5 bits of write frame -> frame_err one pulse, no rx_valid, rx_data unchanged.
REQ-035 rst_n low during RD_SHIFT bit 3 -> MISO=MISO_IDLE, state IDLE, rd_pend=0, no pulses.
REQ-036 DATA_W=16 build: 18-bit write frame 01_BEEF -> rx_data=18'h1BEEF; 16-bit read return 16'h8001 -> MISO 1, fourteen 0s, 1.
